// File: rtl/h264invtransform_pkg.sv
// Shared types and constants for the H.264 4x4 inverse core transform.
package h264invtransform_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      EMIT    = 2'd3
   } state_t;

   localparam int ROUND_CONST = 32;
   localparam int ROUND_SHIFT = 6;

   // Growth over the coefficient width after each 1-D pass.
   localparam int H_GROWTH = 2;
   localparam int V_GROWTH = 4;

endpackage

// File: rtl/h264invtransform_butterfly.sv
// Combinational 4-point inverse butterfly; inputs already sign-extended to W
// bits, which the caller sizes so that no intermediate can overflow.
module h264invtransform_butterfly #(
   parameter int W = 18
) (
   input  logic signed [W-1:0] d0,
   input  logic signed [W-1:0] d1,
   input  logic signed [W-1:0] d2,
   input  logic signed [W-1:0] d3,
   output logic signed [W-1:0] f0,
   output logic signed [W-1:0] f1,
   output logic signed [W-1:0] f2,
   output logic signed [W-1:0] f3
);

   logic signed [W-1:0] e0, e1, e2, e3;

   always_comb begin
      e0 = d0 + d2;
      e1 = d0 - d2;
      e2 = (d1 >>> 1) - d3;
      e3 = d1 + (d3 >>> 1);
      f0 = e0 + e3;
      f1 = e1 + e2;
      f2 = e1 - e2;
      f3 = e0 - e3;
   end

endmodule

// File: rtl/h264invtransform.sv
// 4x4 inverse integer transform: horizontal pass on row entry, vertical pass
// plus (x+32)>>>6 rounding, then four residual rows. H264_INVTRANSFORM_SAT_EN selects saturation.
//
//   state   | meaning
//   IDLE    | waiting for row 0 of a block
//   LOAD    | rows 1..3 being accepted, counter = next row
//   COMPUTE | vertical pass and rounding registered this cycle
//   EMIT    | driving output row [counter], counter 0..3
module h264invtransform
   import h264invtransform_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 9
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     VALID,
   output logic                     READY,
   input  logic [4*IN_WIDTH-1:0]    XXIN,
   output logic                     VALID_OUT,
   output logic [4*OUT_WIDTH-1:0]   XXOUT,
   output logic [1:0]               ROWOUT
);

   localparam int HW = IN_WIDTH + H_GROWTH;
   localparam int VW = IN_WIDTH + V_GROWTH;

`ifdef H264_INVTRANSFORM_SAT_EN
   localparam logic signed [VW-1:0] SAT_MAX = VW'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [VW-1:0] SAT_MIN = VW'(-(1 << (OUT_WIDTH - 1)));
`endif

   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic accept;

   logic signed [HW-1:0]        hin [4];
   logic signed [HW-1:0]        hout [4];
   logic signed [HW-1:0]        buf_q [4][4];
   logic signed [HW-1:0]        buf_d [4][4];
   logic signed [VW-1:0]        vin [4][4];
   logic signed [VW-1:0]        vout [4][4];
   logic signed [OUT_WIDTH-1:0] out_q [4][4];
   logic signed [OUT_WIDTH-1:0] out_d [4][4];

   function automatic logic signed [OUT_WIDTH-1:0] round_out(input logic signed [VW-1:0] v);
      logic signed [VW-1:0] s;
      s = (v + VW'(ROUND_CONST)) >>> ROUND_SHIFT;
`ifdef H264_INVTRANSFORM_SAT_EN
      if (s > SAT_MAX) s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
`endif
      return OUT_WIDTH'(s);
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_hin
      assign hin[gi] = HW'($signed(XXIN[gi*IN_WIDTH +: IN_WIDTH]));
   end

   h264invtransform_butterfly #(.W(HW)) u_hor (
      .d0(hin[0]), .d1(hin[1]), .d2(hin[2]), .d3(hin[3]),
      .f0(hout[0]), .f1(hout[1]), .f2(hout[2]), .f3(hout[3])
   );

   // One vertical butterfly per buffer column; output index f<r> is row r.
   for (genvar gc = 0; gc < 4; gc++) begin : g_ver
      for (genvar gr = 0; gr < 4; gr++) begin : g_ext
         assign vin[gr][gc] = VW'(buf_q[gr][gc]);
      end
      h264invtransform_butterfly #(.W(VW)) u_ver (
         .d0(vin[0][gc]), .d1(vin[1][gc]), .d2(vin[2][gc]), .d3(vin[3][gc]),
         .f0(vout[0][gc]), .f1(vout[1][gc]), .f2(vout[2][gc]), .f3(vout[3][gc])
      );
   end

   assign READY  = (state_q == IDLE) || (state_q == LOAD);
   assign accept = VALID && READY;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LOAD;
               cnt_d   = 2'd1;
            end
         end
         LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = COMPUTE;
                  cnt_d   = 2'd0;
               end
            end
         end
         COMPUTE: begin
            state_d = EMIT;
            cnt_d   = 2'd0;
         end
         EMIT: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_comb begin
      buf_d = buf_q;
      out_d = out_q;
      if (accept) begin
         for (int c = 0; c < 4; c++) buf_d[cnt_q][c] = hout[c];
      end
      if (state_q == COMPUTE) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) out_d[r][c] = round_out(vout[r][c]);
      end
   end

   always_comb begin
      XXOUT     = '0;
      ROWOUT    = 2'd0;
      VALID_OUT = 1'b0;
      if (state_q == EMIT) begin
         VALID_OUT = 1'b1;
         ROWOUT    = cnt_q;
         for (int c = 0; c < 4; c++) XXOUT[c*OUT_WIDTH +: OUT_WIDTH] = out_q[cnt_q][c];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Data arrays need no reset: contents are only observed after a full load.
   always_ff @(posedge CLK) begin
      buf_q <= buf_d;
      out_q <= out_d;
   end

endmodule
